// File: rtl/relay_framer.sv
// relay_framer: relay frame controller for the hi_simulate relay path.
// Samples the decoded relay bitstream on a divided symbol tick, tracks reader/tag
// frames through IDLE/LISTEN/MOD and drives mod_type to the modulation front end.
// Optional feature macro: RELAY_FRAME_STATS_EN enables the completed-frame counter;
// without it frame_count is tied to zero and no counter flops are built.
module relay_framer #(
  parameter int               DIV_BITS       = 4,
  parameter int               BUF_W          = 20,
  parameter int               DATA_TAP       = 3,
  parameter int               MAX_FRAME_BITS = 1024,
  parameter logic [BUF_W-1:0] RD_START       = 20'h0000c,
  parameter logic [BUF_W-1:0] RD_END_A       = 20'h00000,
  parameter logic [BUF_W-1:0] RD_END_B       = 20'hc0000,
  parameter logic [BUF_W-1:0] TG_START       = 20'h0000f,
  parameter int               TG_END_LEN     = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  relay_mode,
  input  logic        data_in,
  input  logic        relay_raw,
  output logic [2:0]  mod_type,
  output logic        data_out,
  output logic        relay_gate,
  output logic        frame_active,
  output logic        frame_timeout,
  output logic [15:0] frame_count
);

  localparam int                  FB_W    = $clog2(MAX_FRAME_BITS + 1);
  localparam logic [FB_W-1:0]     FB_MAX  = FB_W'(MAX_FRAME_BITS);
  localparam logic [DIV_BITS-1:0] TICK_AT = DIV_BITS'(2 ** (DIV_BITS - 1));

  localparam logic [2:0] MODE_READER   = 3'b101;
  localparam logic [2:0] MODE_TAG      = 3'b110;
  localparam logic [2:0] MT_SNIFFER    = 3'b000;
  localparam logic [2:0] MT_TAG_LISTEN = 3'b001;
  localparam logic [2:0] MT_TAG_MOD    = 3'b010;
  localparam logic [2:0] MT_RDR_LISTEN = 3'b011;
  localparam logic [2:0] MT_RDR_MOD    = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LISTEN = 2'b01,
    ST_MOD    = 2'b10
  } state_t;

  state_t              r_state;
  logic [DIV_BITS-1:0] r_div_cnt;
  logic [BUF_W-1:0]    r_buf;
  logic [2:0]          r_phase;
  logic [FB_W-1:0]     r_fbits;
  logic [2:0]          r_mode;
  logic [2:0]          r_mod_type;
  logic                r_frame_active;
  logic                r_frame_timeout;

  logic                w_tick;
  logic                w_mode_active;
  logic                w_mode_drop;
  logic                w_reader;
  logic [BUF_W-1:0]    w_buf_nxt;
  logic [2:0]          w_phase_nxt;
  logic [FB_W-1:0]     w_fbits_nxt;
  logic                w_start_hit;
  logic                w_end_match;
  logic                w_end_hit;

  // The tick lands mid-way through the divider period.
  assign w_tick        = (r_div_cnt == TICK_AT);
  // Any non-active mode, or a switch between active modes, forces a pass through IDLE.
  assign w_mode_active = (relay_mode == MODE_READER) || (relay_mode == MODE_TAG);
  assign w_mode_drop   = !w_mode_active || ((r_state != ST_IDLE) && (relay_mode != r_mode));
  assign w_reader      = (r_mode == MODE_READER);
  // Pattern matches look at the buffer as it will be after this tick's shift.
  assign w_buf_nxt     = {r_buf[BUF_W-2:0], data_in};
  assign w_phase_nxt   = r_phase + 3'd1;
  assign w_fbits_nxt   = (r_fbits == FB_MAX) ? r_fbits : (r_fbits + FB_W'(1));
  // Frames may only close on a byte boundary of the post-increment phase.
  assign w_end_hit     = (w_phase_nxt == 3'd0) && w_end_match;

  // Select start/end pattern matching for the latched mode.
  always_comb begin
    w_start_hit = 1'b0;
    w_end_match = 1'b0;
    if (w_reader) begin
      w_start_hit = (w_buf_nxt == RD_START);
      w_end_match = (w_buf_nxt == RD_END_A) || (w_buf_nxt == RD_END_B);
    end else begin
      w_start_hit = (w_buf_nxt == TG_START);
      w_end_match = (w_buf_nxt[TG_END_LEN-1:0] == '0);
    end
  end

  // Free-running symbol divider.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_BITS'(1);
    end
  end

  // Frame state machine with its registered outputs and receive datapath.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_buf           <= '0;
      r_phase         <= 3'd0;
      r_fbits         <= '0;
      r_mode          <= 3'b000;
      r_mod_type      <= MT_SNIFFER;
      r_frame_active  <= 1'b0;
      r_frame_timeout <= 1'b0;
    end else if (w_mode_drop) begin
      r_state         <= ST_IDLE;
      r_mod_type      <= MT_SNIFFER;
      r_frame_active  <= 1'b0;
      r_frame_timeout <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_state         <= ST_LISTEN;
      r_mode          <= relay_mode;
      r_mod_type      <= (relay_mode == MODE_READER) ? MT_RDR_LISTEN : MT_TAG_LISTEN;
      r_frame_active  <= 1'b0;
      r_frame_timeout <= 1'b0;
    end else if (w_tick) begin
      r_buf           <= w_buf_nxt;
      r_phase         <= w_phase_nxt;
      r_frame_timeout <= 1'b0;
      case (r_state)
        ST_LISTEN: begin
          if (w_start_hit) begin
            r_state        <= ST_MOD;
            r_mod_type     <= w_reader ? MT_RDR_MOD : MT_TAG_MOD;
            r_frame_active <= 1'b1;
            r_phase        <= 3'd0;
            r_fbits        <= '0;
          end else begin
            r_state <= ST_LISTEN;
          end
        end
        ST_MOD: begin
          r_fbits <= w_fbits_nxt;
          if (w_end_hit) begin
            r_state        <= ST_LISTEN;
            r_mod_type     <= w_reader ? MT_RDR_LISTEN : MT_TAG_LISTEN;
            r_frame_active <= 1'b0;
          end else if (w_fbits_nxt == FB_MAX) begin
            r_state         <= ST_LISTEN;
            r_mod_type      <= w_reader ? MT_RDR_LISTEN : MT_TAG_LISTEN;
            r_frame_active  <= 1'b0;
            r_frame_timeout <= 1'b1;
          end else begin
            r_state <= ST_MOD;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_mod_type     <= MT_SNIFFER;
          r_frame_active <= 1'b0;
        end
      endcase
    end else begin
      r_frame_timeout <= 1'b0;
    end
  end

`ifdef RELAY_FRAME_STATS_EN
  logic        w_frame_done;
  logic [15:0] r_frame_count;

  // A frame counts only when it closes on an end pattern, never on timeout.
  assign w_frame_done = !w_mode_drop && (r_state == ST_MOD) && w_tick && w_end_hit;

  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame_count <= 16'h0000;
    end else if (w_frame_done) begin
      r_frame_count <= r_frame_count + 16'h0001;
    end else begin
      r_frame_count <= r_frame_count;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = 16'h0000;
`endif

  assign mod_type      = r_mod_type;
  assign data_out      = r_buf[DATA_TAP];
  assign relay_gate    = relay_raw & (r_state != ST_MOD);
  assign frame_active  = r_frame_active;
  assign frame_timeout = r_frame_timeout;

endmodule

// File: tb/tb_relay_framer.sv
// Self-checking bench for relay_framer: a reference model predicts every cycle's
// outputs into a queue, and a monitor pops and compares after each clock edge.
module tb_relay_framer;

  localparam int MAXF     = 64;
  localparam int S_IDLE   = 0;
  localparam int S_LISTEN = 1;
  localparam int S_MOD    = 2;
`ifdef RELAY_FRAME_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  relay_mode = 3'b000;
  logic        data_in = 1'b0;
  logic        relay_raw = 1'b0;
  logic [2:0]  mod_type;
  logic        data_out;
  logic        relay_gate;
  logic        frame_active;
  logic        frame_timeout;
  logic [15:0] frame_count;

  relay_framer #(.MAX_FRAME_BITS(MAXF)) dut (
    .clk(clk), .reset(reset), .relay_mode(relay_mode), .data_in(data_in),
    .relay_raw(relay_raw), .mod_type(mod_type), .data_out(data_out),
    .relay_gate(relay_gate), .frame_active(frame_active),
    .frame_timeout(frame_timeout), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  mt;
    logic        dout;
    logic        gate;
    logic        act;
    logic        tmo;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  int          m_div = 0, m_st = S_IDLE, m_phase = 0, m_fbits = 0, m_cnt = 0;
  logic [2:0]  m_mode = 3'b000;
  logic [19:0] m_buf = 20'h0;
  bit          m_ticked = 1'b0, m_tmo = 1'b0;
  logic [2:0]  cur_mode = 3'b101;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endfunction

  // Predict the outputs that follow the next rising edge from the inputs just applied.
  task automatic model_step();
    exp_t e;
    bit   tick;
    bit   rdr;
    bit   endm;
    m_ticked = 1'b0;
    m_tmo    = 1'b0;
    if (reset == 1'b0) begin
      m_div = 0; m_buf = 20'h0; m_phase = 0; m_fbits = 0;
      m_st = S_IDLE; m_cnt = 0; m_mode = 3'b000;
    end else begin
      tick     = (m_div == 8);
      m_ticked = tick;
      m_div    = (m_div + 1) % 16;
      if (!(relay_mode == 3'b101 || relay_mode == 3'b110)) begin
        m_st = S_IDLE;
      end else if (m_st != S_IDLE && relay_mode != m_mode) begin
        m_st = S_IDLE;
      end else if (m_st == S_IDLE) begin
        m_st   = S_LISTEN;
        m_mode = relay_mode;
      end else if (tick) begin
        m_buf   = {m_buf[18:0], data_in};
        m_phase = (m_phase + 1) % 8;
        rdr     = (m_mode == 3'b101);
        if (m_st == S_LISTEN) begin
          if (m_buf == (rdr ? 20'h0000c : 20'h0000f)) begin
            m_st = S_MOD; m_phase = 0; m_fbits = 0;
          end
        end else begin
          if (m_fbits < MAXF) m_fbits++;
          endm = (m_phase == 0) &&
                 (rdr ? (m_buf == 20'h00000 || m_buf == 20'hc0000) : (m_buf[11:0] == 12'h000));
          if (endm) begin
            m_st  = S_LISTEN;
            m_cnt = (m_cnt + 1) % 65536;
          end else if (m_fbits == MAXF) begin
            m_st  = S_LISTEN;
            m_tmo = 1'b1;
          end
        end
      end
    end
    rdr   = (m_mode == 3'b101);
    e.mt  = (m_st == S_IDLE) ? 3'd0 : (m_st == S_LISTEN) ? (rdr ? 3'd3 : 3'd1) : (rdr ? 3'd4 : 3'd2);
    e.dout = m_buf[3];
    e.gate = relay_raw & (m_st != S_MOD);
    e.act  = (m_st == S_MOD);
    e.tmo  = m_tmo;
    e.cnt  = (STATS != 0) ? 16'(m_cnt) : 16'h0000;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic [2:0] md, input logic din, input logic raw);
    @(negedge clk);
    reset = rst; relay_mode = md; data_in = din; relay_raw = raw;
    model_step();
  endtask

  // Hold one bit until the model reports the tick that samples it.
  task automatic send_bit(input logic b, input logic raw);
    int n = 0;
    do begin
      cyc(1'b1, cur_mode, b, raw);
      n++;
    end while (!m_ticked && n < 20);
    if (!m_ticked) begin
      n_fail++;
      $display("FAIL tick_bound: actual=no_tick required=tick within 20 clks");
    end
  endtask

  task automatic send_n(input logic b, input int n);
    for (int i = 0; i < n; i++) send_bit(b, 1'($urandom % 2));
  endtask

  task automatic send_start(input logic [19:0] w);
    for (int i = 19; i >= 0; i--) send_bit(w[i], 1'($urandom % 2));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: compare the DUT against the oldest prediction after every edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_mod_type", 16'(mod_type), 16'(e.mt));
      chk("sb_data_out", 16'(data_out), 16'(e.dout));
      chk("sb_relay_gate", 16'(relay_gate), 16'(e.gate));
      chk("sb_frame_active", 16'(frame_active), 16'(e.act));
      chk("sb_frame_timeout", 16'(frame_timeout), 16'(e.tmo));
      chk("sb_frame_count", frame_count, e.cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    // Reset with random inputs (raw held low so the gate is known to be 0).
    repeat (3) cyc(1'b0, 3'($urandom), 1'($urandom % 2), 1'b0);
    settle();
    chk("t1_mod_type", 16'(mod_type), 16'h0);
    chk("t1_data_out", 16'(data_out), 16'h0);
    chk("t1_relay_gate", 16'(relay_gate), 16'h0);
    chk("t1_frame_timeout", 16'(frame_timeout), 16'h0);

    // Reader start.
    cur_mode = 3'b101;
    repeat (2) cyc(1'b1, cur_mode, 1'b0, 1'b0);
    send_n(1'b0, 16);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b1);
    settle();
    chk("t2_mod_type", 16'(mod_type), 16'h4);
    chk("t2_frame_active", 16'(frame_active), 16'h1);
    chk("t2_relay_gate", 16'(relay_gate), 16'h0);

    // Reader end on an aligned END_B, then a misaligned all-zero buffer.
    send_n(1'b0, 15);
    settle();
    chk("t3_before_end", 16'(mod_type), 16'h4);
    send_n(1'b0, 1);
    settle();
    chk("t3_end_mod_type", 16'(mod_type), 16'h3);
    chk("t3_end_count", frame_count, 16'(STATS));
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_n(1'b0, 20);
    settle();
    chk("t3_misaligned", 16'(mod_type), 16'h4);
    send_n(1'b0, 3);
    settle();
    chk("t3_aligned", 16'(mod_type), 16'h3);
    chk("t3_count2", frame_count, 16'(2 * STATS));

    // Tag frame.
    cur_mode = 3'b110;
    repeat (2) cyc(1'b1, cur_mode, 1'b0, 1'b0);
    send_n(1'b0, 16);
    send_n(1'b1, 4);
    settle();
    chk("t4_tag_mod", 16'(mod_type), 16'h2);
    send_n(1'b0, 12);
    settle();
    chk("t4_tag_misaligned", 16'(mod_type), 16'h2);
    send_n(1'b0, 4);
    settle();
    chk("t4_tag_end", 16'(mod_type), 16'h1);

    // Reader timeout.
    cur_mode = 3'b101;
    repeat (2) cyc(1'b1, cur_mode, 1'b0, 1'b0);
    send_n(1'b0, 16);
    send_start(20'h0000c);
    send_n(1'b1, 63);
    settle();
    chk("t5_pre_timeout", 16'(mod_type), 16'h4);
    send_n(1'b1, 1);
    settle();
    chk("t5_timeout_pulse", 16'(frame_timeout), 16'h1);
    chk("t5_mod_type", 16'(mod_type), 16'h3);
    chk("t5_count", frame_count, 16'(3 * STATS));

    // Mid-frame mode drop, then mid-frame reset.
    send_n(1'b0, 16);
    send_start(20'h0000c);
    send_n(1'b0, 3);
    cyc(1'b1, 3'b000, 1'b0, 1'b1);
    settle();
    chk("t6_drop_mod_type", 16'(mod_type), 16'h0);
    chk("t6_drop_active", 16'(frame_active), 16'h0);
    repeat (2) cyc(1'b1, cur_mode, 1'b0, 1'b0);
    send_start(20'h0000c);
    send_n(1'b1, 2);
    cyc(1'b0, cur_mode, 1'($urandom % 2), 1'b0);
    settle();
    chk("t6_rst_mod_type", 16'(mod_type), 16'h0);
    chk("t6_rst_data_out", 16'(data_out), 16'h0);
    chk("t6_rst_active", 16'(frame_active), 16'h0);
    chk("t6_rst_count", frame_count, 16'h0);

    // Randomised traffic against the model.
    repeat (2) cyc(1'b1, cur_mode, 1'b0, 1'b0);
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        repeat ($urandom_range(1, 3)) cyc(1'b0, 3'($urandom), 1'($urandom % 2), 1'($urandom % 2));
      end else if (r < 12) begin
        r = $urandom_range(0, 9);
        cur_mode = (r < 6) ? 3'b101 : (r < 9) ? 3'b110 : 3'($urandom);
        repeat (2) cyc(1'b1, cur_mode, 1'($urandom % 2), 1'($urandom % 2));
      end else if (r < 40) begin
        send_start((cur_mode == 3'b110) ? 20'h0000f : 20'h0000c);
      end else begin
        repeat ($urandom_range(1, 24)) send_bit(1'($urandom_range(0, 3) == 0), 1'($urandom % 2));
      end
    end

    repeat (3) cyc(1'b1, cur_mode, 1'b0, 1'b0);
    settle();
    #5;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
